eda_region_compare: RTL and testbench
=====================================

# eda_region_compare

Parametrised successor to the 3x3 regional-max comparator in the imregionalmax datapath. Accepts one K×K window per handshake and masks neighbours by validity and connectivity mode (4/8). Produces a registered regional-max verdict and equal-neighbour vector, then serialises the un-iterated equal neighbours one per cycle to the flood-fill FIFO under ready/valid. Sits between the window fetcher and the push FIFO.

## Interface
- `PIXEL_WIDTH`, 8, unsigned pixel width
- `K`, 3, odd window side (≥3); WINDOW = K*K, NEIGH = WINDOW-1, CENTRE = (WINDOW-1)/2
- `IDX_WIDTH`, $clog2(NEIGH), neighbour index width
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: window request
- `in_ready` out 1: block idle, can accept
- `window_values` in PIXEL_WIDTH*WINDOW: pixel w at [w*PIXEL_WIDTH +: PIXEL_WIDTH], row-major, centre at CENTRE
- `neigh_valid` in NEIGH: neighbour inside image
- `iterated_idx` in NEIGH: neighbour already visited
- `conn4` in 1: 1 = 4-connectivity, 0 = 8-connectivity (full window)
- `result_valid` out 1: one-cycle pulse, verdict valid
- `compare_out` out 1: centre ≥ every enabled neighbour
- `equal_positions` out NEIGH: enabled neighbours equal to window max
- `push_valid` out 1, `push_ready` in 1: push handshake
- `push_idx` out IDX_WIDTH: neighbour index to push
- `push_last` out 1: current push is final for this window

## Operation
- Neighbour index n maps to window w = n (n < CENTRE) or n+1 (n ≥ CENTRE).
- Enable mask en[n] = neigh_valid[n] & conn_mask[n]. conn_mask is all-ones when conn4=0. When conn4=1, it covers window cells sharing the centre's row or column.
- max = unsigned max of the centre and all enabled neighbours; disabled neighbours do not participate.
- compare_out = (centre == max); it is 1 when no neighbour is enabled.
- equal_positions[n] = en[n] & (neighbour n == max).
- Push set P = equal_positions & ~iterated_idx, computed regardless of compare_out.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture all inputs and go to CALC.
  - CALC: evaluate the max tree on the captured data and register the verdict. Go to DRAIN if P≠0, else IDLE.
  - DRAIN: push_valid=1 and push_idx = lowest set bit of remaining P. push_last=1 when exactly one bit remains. On push_valid&push_ready, clear that bit; if it was the last, go to IDLE.
- compare_out and equal_positions hold their value until the next CALC.
- in_valid outside IDLE is ignored; the upstream holds it.

## Timing
- Reset values: in_ready=1 (state IDLE), result_valid=0, compare_out=0, equal_positions=0, push_valid=0, push_idx=0, push_last=0, internal P=0.
- Accept at cycle t. CALC at t+1. result_valid=1 and outputs updated at t+2. If P≠0, push_valid=1 from t+2.
- Empty P: IDLE at t+2, so the next accept is possible at t+2 (throughput 1 window / 2 cycles).
- With m pushes and push_ready held high: push on t+2 … t+m+1; IDLE, and so in_ready=1, at t+m+2.
- push_ready low stalls DRAIN; push_idx and push_last stay stable while push_valid=1 and push_ready=0.
- Reset asserted in any state returns to IDLE next cycle and discards pending pushes. No partial push survives.

## Structure
- `eda_pkg` holds:
  - state enum (IDLE, CALC, DRAIN)
  - function `neigh_to_win(n)`
  - function `conn4_mask(K)`
  - function `lowest_one(vec)` returning index and one-hot
- Sub-module `eda_max_tree`: parametrised (PIXEL_WIDTH, NUM) combinational max reduction with per-input enable, built from `eda_max` pairs. Handles odd NUM by pass-through, and disabled inputs are treated as 0.
- Top holds the capture registers, FSM, verdict registers and push serialiser.

## Test plan
- K=3, 8-conn, centre 50, all neighbours 10, all valid -> compare_out=1, equal_positions=0, no push, in_ready back at t+2.
- Neighbour 7=80 (others 10), centre 50 -> compare_out=0, equal_positions=8'b1000_0000, single push idx 7 with push_last=1.
- Centre 50, neighbours 1,3,6 = 50, iterated_idx=8'b0000_1000, push_ready=1 -> equal_positions=8'b0100_1010; pushes idx 1 then 6 (push_last on 6); IDLE at t+4.
- conn4=1, diagonal neighbour 0 = 90, others 20, centre 40 -> compare_out=1 and neighbour 0 ignored. Repeat with conn4=0 -> compare_out=0 and push idx 0.
- neigh_valid=0 (corner pixel), any values -> compare_out=1, equal_positions=0, no push.
- Three pushes pending, push_ready low for 3 cycles, then reset asserted mid-DRAIN -> push_idx stable during the stall; after reset, push_valid=0 and in_ready=1. Next window is processed normally.
- K=5, PIXEL_WIDTH=12, centre 4095 equal to neighbour 23 -> compare_out=1, push idx 23.

Source files
------------

// File: rtl/eda_region_compare_pkg.sv
// Shared types and elaboration helpers for the regional-max comparator.
// Helper vectors are sized for windows up to K=11.
package eda_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_t;

    localparam int MAX_NEIGH = 128;
    localparam int MAX_IDX_W = 8;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_NEIGH-1:0] onehot;
    } lowest_t;

    function automatic int neigh_to_win(input int n, input int k);
        return (n < (k*k-1)/2) ? n : n + 1;
    endfunction

    function automatic logic [MAX_NEIGH-1:0] conn4_mask(input int k);
        logic [MAX_NEIGH-1:0] m;
        int w;
        int c;
        m = '0;
        c = (k-1)/2;
        for (int n = 0; n < k*k-1; n++) begin
            w = neigh_to_win(n, k);
            m[n] = ((w / k) == c) || ((w % k) == c);
        end
        return m;
    endfunction

    function automatic lowest_t lowest_one(input logic [MAX_NEIGH-1:0] vec);
        lowest_t r;
        r.onehot = vec & (~vec + MAX_NEIGH'(1));
        r.idx    = '0;
        for (int i = 0; i < MAX_NEIGH; i++) begin
            if (r.onehot[i]) r.idx = MAX_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/eda_region_compare_max_tree.sv
// Enable-masked unsigned max reduction; disabled inputs contribute 0.
module eda_max #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic [PIXEL_WIDTH-1:0] a_i,
    input  logic [PIXEL_WIDTH-1:0] b_i,
    output logic [PIXEL_WIDTH-1:0] max_o
);
    assign max_o = (a_i > b_i) ? a_i : b_i;
endmodule

module eda_max_tree #(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM         = 2
) (
    input  logic [NUM*PIXEL_WIDTH-1:0] data_i,
    input  logic [NUM-1:0]             en_i,
    output logic [PIXEL_WIDTH-1:0]     max_o
);
    generate
        if (NUM == 1) begin : g_leaf
            assign max_o = en_i[0] ? data_i : '0;
        end else begin : g_split
            // Unequal halves absorb an odd input count, so the spare lane passes straight up.
            localparam int LO = NUM / 2;
            localparam int HI = NUM - LO;
            logic [PIXEL_WIDTH-1:0] max_lo, max_hi;

            eda_max_tree #(.PIXEL_WIDTH(PIXEL_WIDTH), .NUM(LO)) u_lo (
                .data_i (data_i[LO*PIXEL_WIDTH-1:0]),
                .en_i   (en_i[LO-1:0]),
                .max_o  (max_lo)
            );
            eda_max_tree #(.PIXEL_WIDTH(PIXEL_WIDTH), .NUM(HI)) u_hi (
                .data_i (data_i[NUM*PIXEL_WIDTH-1:LO*PIXEL_WIDTH]),
                .en_i   (en_i[NUM-1:LO]),
                .max_o  (max_hi)
            );
            eda_max #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_max (
                .a_i   (max_lo),
                .b_i   (max_hi),
                .max_o (max_o)
            );
        end
    endgenerate
endmodule

// File: rtl/eda_region_compare.sv
// Regional-max verdict for one KxK window, then serialises un-iterated equal
// neighbours one per handshake to the flood-fill push FIFO.
module eda_region_compare
    import eda_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int K           = 3,
    parameter int IDX_WIDTH   = $clog2(K*K-1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIXEL_WIDTH*K*K-1:0] window_values,
    input  logic [K*K-2:0]             neigh_valid,
    input  logic [K*K-2:0]             iterated_idx,
    input  logic                       conn4,
    output logic                       result_valid,
    output logic                       compare_out,
    output logic [K*K-2:0]             equal_positions,
    output logic                       push_valid,
    input  logic                       push_ready,
    output logic [IDX_WIDTH-1:0]       push_idx,
    output logic                       push_last
);
    localparam int WINDOW = K*K;
    localparam int NEIGH  = WINDOW - 1;
    localparam int CENTRE = (WINDOW - 1) / 2;
    localparam logic [MAX_NEIGH-1:0] CONN4_MASK = conn4_mask(K);

    state_t                        state_q, state_d;
    logic [PIXEL_WIDTH*WINDOW-1:0] win_q;
    logic [NEIGH-1:0]              nvalid_q, iter_q;
    logic                          conn4_q;
    logic                          result_valid_q, result_valid_d;
    logic                          compare_q, compare_d;
    logic [NEIGH-1:0]              equal_q, equal_d;
    logic [NEIGH-1:0]              pend_q, pend_d;

    logic [NEIGH-1:0]       en, eq_now;
    logic [WINDOW-1:0]      win_en;
    logic [PIXEL_WIDTH-1:0] max_val, centre_val;
    lowest_t                lo;
    logic [NEIGH-1:0]       lo_onehot;
    logic                   unused_lo;

    // Verdict: masked max over the captured window; the centre always takes part.
    assign en             = nvalid_q & (conn4_q ? CONN4_MASK[NEIGH-1:0] : {NEIGH{1'b1}});
    assign win_en[CENTRE] = 1'b1;
    assign centre_val     = win_q[CENTRE*PIXEL_WIDTH +: PIXEL_WIDTH];

    generate
        for (genvar n = 0; n < NEIGH; n++) begin : g_neigh
            localparam int W = neigh_to_win(n, K);
            assign win_en[W] = en[n];
            assign eq_now[n] = en[n] && (win_q[W*PIXEL_WIDTH +: PIXEL_WIDTH] == max_val);
        end
    endgenerate

    eda_max_tree #(.PIXEL_WIDTH(PIXEL_WIDTH), .NUM(WINDOW)) u_max_tree (
        .data_i (win_q),
        .en_i   (win_en),
        .max_o  (max_val)
    );

    // Serialiser: lowest remaining bit of the pending set is offered next.
    assign lo        = lowest_one({{(MAX_NEIGH-NEIGH){1'b0}}, pend_q});
    assign lo_onehot = lo.onehot[NEIGH-1:0];
    assign unused_lo = ^{lo.idx[MAX_IDX_W-1:IDX_WIDTH], lo.onehot[MAX_NEIGH-1:NEIGH]};

    always_comb begin
        state_d        = state_q;
        result_valid_d = 1'b0;
        compare_d      = compare_q;
        equal_d        = equal_q;
        pend_d         = pend_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                result_valid_d = 1'b1;
                compare_d      = (centre_val == max_val);
                equal_d        = eq_now;
                pend_d         = eq_now & ~iter_q;
                state_d        = (|(eq_now & ~iter_q)) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (push_ready) begin
                    pend_d = pend_q & ~lo_onehot;
                    if (pend_q == lo_onehot) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            compare_q      <= 1'b0;
            equal_q        <= '0;
            pend_q         <= '0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            compare_q      <= compare_d;
            equal_q        <= equal_d;
            pend_q         <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            win_q    <= window_values;
            nvalid_q <= neigh_valid;
            iter_q   <= iterated_idx;
            conn4_q  <= conn4;
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign push_valid      = (state_q == DRAIN);
    assign push_idx        = lo.idx[IDX_WIDTH-1:0];
    assign push_last       = push_valid && (pend_q == lo_onehot);
    assign result_valid    = result_valid_q;
    assign compare_out     = compare_q;
    assign equal_positions = equal_q;

endmodule

// File: tb/tb_eda_region_compare.sv
// Bench for eda_region_compare: K=3 vector table with verdict/push scoreboard,
// stall-then-reset sequence, and a K=5 / 12-bit instance.
module tb_eda_region_compare;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, conn4, result_valid, compare_out;
    logic [71:0] window_values;
    logic [7:0]  neigh_valid, iterated_idx, equal_positions;
    logic        push_valid, push_ready, push_last;
    logic [2:0]  push_idx;

    logic         iv5, ir5, c4_5, rv5, cmp5, pv5, pr5, pl5;
    logic [299:0] win5;
    logic [23:0]  nv5, it5, eq5;
    logic [4:0]   pi5;

    eda_region_compare #(.PIXEL_WIDTH(8), .K(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .window_values(window_values), .neigh_valid(neigh_valid),
        .iterated_idx(iterated_idx), .conn4(conn4), .result_valid(result_valid),
        .compare_out(compare_out), .equal_positions(equal_positions),
        .push_valid(push_valid), .push_ready(push_ready), .push_idx(push_idx),
        .push_last(push_last)
    );

    eda_region_compare #(.PIXEL_WIDTH(12), .K(5)) dut5 (
        .clk(clk), .reset(reset), .in_valid(iv5), .in_ready(ir5),
        .window_values(win5), .neigh_valid(nv5), .iterated_idx(it5), .conn4(c4_5),
        .result_valid(rv5), .compare_out(cmp5), .equal_positions(eq5),
        .push_valid(pv5), .push_ready(pr5), .push_idx(pi5), .push_last(pl5)
    );

    typedef struct {
        logic [7:0]  centre;
        logic [63:0] nb;
        logic [7:0]  valid;
        logic [7:0]  iter;
        logic        conn4;
        logic        exp_cmp;
        logic [7:0]  exp_eq;
    } vec_t;
    typedef struct { logic cmp; logic [7:0] eq; } verd_t;
    typedef struct { logic [2:0] idx; logic last; } push_t;

    vec_t  tbl [9];
    verd_t vq[$];
    push_t pq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] nb_fill(input logic [7:0] base, input logic [7:0] sel,
                                            input logic [7:0] val);
        logic [63:0] r;
        for (int n = 0; n < 8; n++) r[n*8 +: 8] = sel[n] ? val : base;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        int n;
        for (int w = 0; w < 9; w++) begin
            n = (w < 4) ? w : w - 1;
            window_values[w*8 +: 8] = (w == 4) ? v.centre : v.nb[n*8 +: 8];
        end
        neigh_valid  = v.valid;
        iterated_idx = v.iter;
        conn4        = v.conn4;
    endtask

    // Expected verdict plus pushes in ascending index order, last one flagged.
    task automatic expect_model(input vec_t v, output int m);
        logic [7:0] p;
        int rem;
        p = v.exp_eq & ~v.iter;
        m = $countones(p);
        rem = m;
        vq.push_back('{v.exp_cmp, v.exp_eq});
        for (int n = 0; n < 8; n++) begin
            if (p[n]) begin
                rem--;
                pq.push_back('{3'(n), (rem == 0)});
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int m;
        int n;
        chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        drive(v);
        expect_model(v, m);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk({tag, "_rv_t2"}, 64'(result_valid), 64'(1));
                chk({tag, "_pv_t2"}, 64'(push_valid), 64'(m != 0));
            end
        end while (!in_ready && n < 50);
        chk({tag, "_idle_lat"}, 64'(n), 64'(m + 1));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid) begin
                if (vq.size() == 0) begin
                    chk("verdict_unexpected", 64'(result_valid), 64'(0));
                end else begin
                    verd_t e;
                    e = vq.pop_front();
                    chk("verdict_cmp", 64'(compare_out), 64'(e.cmp));
                    chk("verdict_eq", 64'(equal_positions), 64'(e.eq));
                end
            end
            if (push_valid && push_ready) begin
                if (pq.size() == 0) begin
                    chk("push_unexpected", 64'(push_valid), 64'(0));
                end else begin
                    push_t e;
                    e = pq.pop_front();
                    chk("push_idx", 64'(push_idx), 64'(e.idx));
                    chk("push_last", 64'(push_last), 64'(e.last));
                end
            end
        end
    end

    task automatic k5_run(input logic cn, input logic ecmp, input logic [23:0] eeq,
                          input logic epv, input logic [4:0] eidx);
        for (int w = 0; w < 25; w++)
            win5[w*12 +: 12] = (w == 12 || w == 24) ? 12'hFFF : 12'd100;
        nv5  = '1;
        it5  = '0;
        c4_5 = cn;
        iv5  = 1'b1;
        @(posedge clk); #1;
        iv5 = 1'b0;
        @(posedge clk); #1;
        chk("k5_rv", 64'(rv5), 64'(1));
        chk("k5_cmp", 64'(cmp5), 64'(ecmp));
        chk("k5_eq", 64'(eq5), 64'(eeq));
        chk("k5_pv", 64'(pv5), 64'(epv));
        chk("k5_idx", 64'(pi5), 64'(eidx));
        chk("k5_last", 64'(pl5), 64'(epv));
        @(posedge clk); #1;
        chk("k5_rdy", 64'(ir5), 64'(1));
        chk("k5_pv_done", 64'(pv5), 64'(0));
    endtask

    initial begin
        vec_t s;
        reset = 1'b1; in_valid = 1'b0; push_ready = 1'b1; conn4 = 1'b0;
        window_values = '0; neigh_valid = '0; iterated_idx = '0;
        iv5 = 1'b0; pr5 = 1'b1; c4_5 = 1'b0; win5 = '0; nv5 = '0; it5 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_result_valid", 64'(result_valid), 64'(0));
        chk("rst_compare", 64'(compare_out), 64'(0));
        chk("rst_equal", 64'(equal_positions), 64'(0));
        chk("rst_push_valid", 64'(push_valid), 64'(0));
        chk("rst_push_idx", 64'(push_idx), 64'(0));
        chk("rst_push_last", 64'(push_last), 64'(0));

        tbl[0] = '{8'd50, nb_fill(8'd10, 8'h00, 8'd0),   8'hFF, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[1] = '{8'd50, nb_fill(8'd10, 8'h80, 8'd80),  8'hFF, 8'h00, 1'b0, 1'b0, 8'h80};
        tbl[2] = '{8'd50, nb_fill(8'd10, 8'h4A, 8'd50),  8'hFF, 8'h08, 1'b0, 1'b1, 8'h4A};
        tbl[3] = '{8'd40, nb_fill(8'd20, 8'h01, 8'd90),  8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[4] = '{8'd40, nb_fill(8'd20, 8'h01, 8'd90),  8'hFF, 8'h00, 1'b0, 1'b0, 8'h01};
        tbl[5] = '{8'd3,  nb_fill(8'd200, 8'h00, 8'd0),  8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[6] = '{8'd60, nb_fill(8'd255, 8'h5A, 8'd70), 8'hFF, 8'h00, 1'b1, 1'b0, 8'h5A};
        tbl[7] = '{8'd99, nb_fill(8'd0, 8'hF0, 8'd255) | (64'd99 << 16),
                   8'h0F, 8'h04, 1'b0, 1'b1, 8'h04};
        tbl[8] = '{8'd0,  64'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF};

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Three pushes stalled, upstream keeps in_valid high, then reset mid-DRAIN.
        s = '{8'd50, nb_fill(8'd10, 8'h25, 8'd50), 8'hFF, 8'h00, 1'b0, 1'b1, 8'h25};
        push_ready = 1'b0;
        drive(s);
        vq.push_back('{1'b1, 8'h25});
        in_valid = 1'b1;
        @(posedge clk); #1;
        window_values = '1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pv", 64'(push_valid), 64'(1));
            chk("stall_idx", 64'(push_idx), 64'(0));
            chk("stall_last", 64'(push_last), 64'(0));
            chk("stall_rdy", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("drain_rst_pv", 64'(push_valid), 64'(0));
        chk("drain_rst_rdy", 64'(in_ready), 64'(1));
        chk("drain_rst_idx", 64'(push_idx), 64'(0));
        chk("drain_rst_last", 64'(push_last), 64'(0));
        chk("drain_rst_eq", 64'(equal_positions), 64'(0));
        push_ready = 1'b1;
        run_vec(tbl[1], "post_rst");
        run_vec(tbl[2], "post_rst2");

        k5_run(1'b0, 1'b1, 24'h80_0000, 1'b1, 5'd23);
        k5_run(1'b1, 1'b1, 24'h00_0000, 1'b0, 5'd0);

        repeat (2) @(posedge clk); #1;
        chk("verdict_queue_empty", 64'(vq.size()), 64'(0));
        chk("push_queue_empty", 64'(pq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
